elevator_shaft: RTL and testbench
=================================

ELEVATOR_SHAFT -- requirements
Module: elevator_shaft

Interface
REQ-001 SHALL provide parameter TRAVEL_TICKS, default 4: ticks for one floor-to-floor trip (legal 2..15).
REQ-002 SHALL provide port CLK  input  1  system clock, rising edge.
REQ-003 SHALL provide port RST  input  1  reset, asynchronous, active-low.
REQ-004 SHALL provide port tick  input  1  single-cycle motion strobe, sampled on CLK.
REQ-005 SHALL provide port engine  input  2  motor command: 00 off, 10 up, 11 down, 01 illegal.
REQ-006 SHALL provide port doors  input  3  door open per floor, bit0 = floor 1.
REQ-007 SHALL provide port floor_sensor  output  3  one-hot car-level indication, bit0 = floor 1; 000 between floors.
REQ-008 SHALL provide port car_pos  output  POSW  car position in ticks, 0 = floor 1; POSW = clog2(2*TRAVEL_TICKS+1).
REQ-009 SHALL provide port moving  output  1  high while the state is UP or DOWN.
REQ-010 SHALL provide port arrived  output  1  one-cycle pulse on reaching a floor level.
REQ-011 SHALL provide port fault  output  1  sticky fault flag.
REQ-012 SHALL provide port fault_code  output  3  first fault detected, 0 = none.

Function
REQ-013 SHALL place the floor levels at car_pos 0, TRAVEL_TICKS and 2*TRAVEL_TICKS.
REQ-014 SHALL implement states IDLE, UP, DOWN and FAULT.
REQ-015 SHALL, in IDLE on a tick: engine 10 -> UP, car_pos+1; engine 11 -> DOWN, car_pos-1; engine 00 -> hold.
REQ-016 SHALL, in UP/DOWN on a tick, step car_pos by +1/-1 per engine; engine 00 -> IDLE, car_pos held.
REQ-017 SHALL leave car_pos unchanged on cycles with tick=0.
REQ-018 SHALL register all outputs; floor_sensor and arrived reflect the car_pos update one CLK after the tick.
REQ-019 SHALL pulse arrived for exactly one cycle when a step lands on a floor level; never while holding.
REQ-020 SHALL check these fault conditions every CLK cycle, tick or not:
- code 5: engine = 01.
- code 3: more than one doors bit set.
- code 1: any doors bit set while engine != 00 or state is UP/DOWN.
- code 2: a doors bit set for a floor other than the current floor_sensor bit, including while between floors.
REQ-021 SHALL check these fault conditions on tick cycles only:
- code 4 overtravel: up at 2*TRAVEL_TICKS, or down at 0.
- code 6 reversal: engine opposite to the current UP/DOWN state without an intervening tick with engine 00.
REQ-022 SHALL, on simultaneous faults, record the highest-priority code; priority order is 5, 3, 1, 2, 4, 6.
REQ-023 SHALL, on any fault, enter FAULT next cycle with fault=1 and fault_code latched.
REQ-024 SHALL, in FAULT, freeze car_pos and floor_sensor, hold moving=0 and arrived=0, and ignore all inputs until reset.
REQ-025 SHALL not apply the faulting step: car_pos keeps its pre-fault value.

Reset
REQ-026 SHALL, while RST=0, asynchronously force state IDLE, car_pos=0, floor_sensor=001, moving=0, arrived=0, fault=0 and fault_code=0.
REQ-027 SHALL treat reset asserted mid-travel or in FAULT identically: car returns to floor 1 with no residual state.
REQ-028 SHALL ignore tick in the first CLK cycle after RST deasserts.

Structure
REQ-029 SHALL place engine encodings (ENG_OFF, ENG_UP, ENG_DOWN), fault codes and the state enum in shared package elevator_pkg, also used by the controller.
REQ-030 SHALL place fault detection and prioritisation in one combinational sub-module, elevator_fault_check; the position counter and FSM remain in elevator_shaft.

Verification (TRAVEL_TICKS=4)
REQ-031 SHALL cover reset: RST low mid-travel at car_pos=3 -> car_pos=0, floor_sensor=001, fault=0, arrived=0.
REQ-032 SHALL cover travel: engine=10 for 8 ticks, doors=000 -> floor_sensor=010 with arrived pulse after tick 4, 100 with arrived pulse after tick 8, car_pos=8; engine=00 then -> moving=0.
REQ-033 SHALL cover overtravel: at car_pos=8, engine=10 plus tick -> fault=1, fault_code=4, car_pos stays 8.
REQ-034 SHALL cover door interlock: at floor 1, engine=10 with doors=001 -> fault_code=1 next cycle; the doors=011 variant -> fault_code=3.
REQ-035 SHALL cover reversal: UP at car_pos=2, engine=11 plus tick -> fault_code=6; engine=01 at any time -> fault_code=5.
REQ-036 SHALL cover misalignment: at car_pos=4, engine=00 with doors=100 -> fault_code=2, floor_sensor stays 010.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator shaft model: engine encodings, fault codes,
// controller states and the car-position to floor-sensor decode.
package elevator_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        UP    = 2'd1,
        DOWN  = 2'd2,
        FAULT = 2'd3
    } state_t;

    localparam logic [1:0] ENG_OFF  = 2'b00;
    localparam logic [1:0] ENG_BAD  = 2'b01;
    localparam logic [1:0] ENG_UP   = 2'b10;
    localparam logic [1:0] ENG_DOWN = 2'b11;

    localparam logic [2:0] FC_NONE       = 3'd0;
    localparam logic [2:0] FC_DOOR_MOVE  = 3'd1;
    localparam logic [2:0] FC_MISALIGN   = 3'd2;
    localparam logic [2:0] FC_MULTI_DOOR = 3'd3;
    localparam logic [2:0] FC_OVERTRAVEL = 3'd4;
    localparam logic [2:0] FC_ENGINE     = 3'd5;
    localparam logic [2:0] FC_REVERSAL   = 3'd6;

    // Floor levels sit at 0, travel and 2*travel; anything else is between floors.
    function automatic logic [2:0] level_sensor(input int pos, input int travel);
        logic [2:0] sensor;
        sensor = 3'b000;
        if (pos == 0)
            sensor = 3'b001;
        else if (pos == travel)
            sensor = 3'b010;
        else if (pos == 2 * travel)
            sensor = 3'b100;
        return sensor;
    endfunction

endpackage

// File: rtl/elevator_fault_check.sv
// Combinational safety checker: evaluates every fault condition for the current
// cycle and reports the single highest-priority code.
module elevator_fault_check
    import elevator_pkg::*;
#(
    parameter int TRAVEL_TICKS = 4,
    parameter int POSW         = $clog2(2 * TRAVEL_TICKS + 1)
) (
    input  state_t           state,
    input  logic             tick,
    input  logic [1:0]       engine,
    input  logic [2:0]       doors,
    input  logic [2:0]       floor_sensor,
    input  logic [POSW-1:0]  car_pos,
    output logic             hit,
    output logic [2:0]       code
);

    localparam logic [POSW-1:0] TOP_POS = POSW'(2 * TRAVEL_TICKS);

    logic engine_bad;
    logic multi_door;
    logic door_move;
    logic misalign;
    logic overtravel;
    logic reversal;
    logic in_motion;

    assign in_motion  = (state == UP) || (state == DOWN);
    assign engine_bad = (engine == ENG_BAD);
    assign multi_door = (doors[0] & doors[1]) | (doors[0] & doors[2]) | (doors[1] & doors[2]);
    assign door_move  = (doors != 3'b000) && ((engine != ENG_OFF) || in_motion);
    assign misalign   = ((doors & ~floor_sensor) != 3'b000);

    // Motion checks only make sense on the strobe that would actually move the car.
    assign overtravel = tick && (((engine == ENG_UP)   && (car_pos == TOP_POS)) ||
                                 ((engine == ENG_DOWN) && (car_pos == '0)));
    assign reversal   = tick && (((state == UP)   && (engine == ENG_DOWN)) ||
                                 ((state == DOWN) && (engine == ENG_UP)));

    always_comb begin
        code = FC_NONE;
        if (engine_bad)
            code = FC_ENGINE;
        else if (multi_door)
            code = FC_MULTI_DOOR;
        else if (door_move)
            code = FC_DOOR_MOVE;
        else if (misalign)
            code = FC_MISALIGN;
        else if (overtravel)
            code = FC_OVERTRAVEL;
        else if (reversal)
            code = FC_REVERSAL;
    end

    assign hit = (code != FC_NONE);

endmodule

// File: rtl/elevator_shaft.sv
// Three-floor elevator shaft: tick-driven car position counter, motion FSM and
// registered floor/arrival/fault indications.
module elevator_shaft
    import elevator_pkg::*;
#(
    parameter  int TRAVEL_TICKS = 4,
    localparam int POSW         = $clog2(2 * TRAVEL_TICKS + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             tick,
    input  logic [1:0]       engine,
    input  logic [2:0]       doors,
    output logic [2:0]       floor_sensor,
    output logic [POSW-1:0]  car_pos,
    output logic             moving,
    output logic             arrived,
    output logic             fault,
    output logic [2:0]       fault_code
);

    state_t          state;
    state_t          state_nx;
    logic [POSW-1:0] pos_nx;
    logic [2:0]      sensor_nx;
    logic            step;
    logic            first_cycle;
    logic            tick_eff;
    logic            chk_hit;
    logic [2:0]      chk_code;

    // The strobe is masked for the first cycle out of reset so a stale tick cannot move the car.
    assign tick_eff = tick & ~first_cycle;

    elevator_fault_check #(
        .TRAVEL_TICKS (TRAVEL_TICKS),
        .POSW         (POSW)
    ) u_fault_check (
        .state        (state),
        .tick         (tick_eff),
        .engine       (engine),
        .doors        (doors),
        .floor_sensor (floor_sensor),
        .car_pos      (car_pos),
        .hit          (chk_hit),
        .code         (chk_code)
    );

    // A detected fault suppresses the step of the same cycle, so the car keeps its pre-fault position.
    always_comb begin
        state_nx  = state;
        pos_nx    = car_pos;
        step      = 1'b0;
        if (state != FAULT) begin
            if (chk_hit) begin
                state_nx = FAULT;
            end else if (tick_eff) begin
                case (engine)
                    ENG_UP: begin
                        state_nx = UP;
                        pos_nx   = car_pos + POSW'(1);
                        step     = 1'b1;
                    end
                    ENG_DOWN: begin
                        state_nx = DOWN;
                        pos_nx   = car_pos - POSW'(1);
                        step     = 1'b1;
                    end
                    ENG_OFF: begin
                        state_nx = IDLE;
                    end
                    default: begin
                        state_nx = state;
                    end
                endcase
            end
        end
        sensor_nx = level_sensor(int'(pos_nx), TRAVEL_TICKS);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state        <= IDLE;
            car_pos      <= '0;
            floor_sensor <= 3'b001;
            moving       <= 1'b0;
            arrived      <= 1'b0;
            fault        <= 1'b0;
            fault_code   <= FC_NONE;
            first_cycle  <= 1'b1;
        end else begin
            first_cycle  <= 1'b0;
            state        <= state_nx;
            car_pos      <= pos_nx;
            floor_sensor <= sensor_nx;
            moving       <= (state_nx == UP) || (state_nx == DOWN);
            arrived      <= step && (sensor_nx != 3'b000);
            if ((state != FAULT) && (state_nx == FAULT)) begin
                fault      <= 1'b1;
                fault_code <= chk_code;
            end
        end
    end

endmodule

// File: tb/tb_elevator_shaft.sv
// Table-driven scoreboard bench for elevator_shaft with TRAVEL_TICKS=4: each
// sequence is a short vector table run after a checked asynchronous reset.
module tb_elevator_shaft;
    import elevator_pkg::*;

    localparam int TRAVEL_TICKS = 4;
    localparam int POSW         = $clog2(2 * TRAVEL_TICKS + 1);

    logic            CLK    = 1'b0;
    logic            RST    = 1'b0;
    logic            tick   = 1'b0;
    logic [1:0]      engine = ENG_OFF;
    logic [2:0]      doors  = 3'b000;
    logic [2:0]      floor_sensor;
    logic [POSW-1:0] car_pos;
    logic            moving;
    logic            arrived;
    logic            fault;
    logic [2:0]      fault_code;

    typedef struct packed {
        logic [POSW-1:0] pos;
        logic [2:0]      sensor;
        logic            moving;
        logic            arrived;
        logic            fault;
        logic [2:0]      code;
    } out_t;

    typedef struct {
        string      name;
        logic       tick;
        logic [1:0] engine;
        logic [2:0] doors;
        out_t       exp;
    } vec_t;

    vec_t vecs[$];
    out_t exp_q[$];
    int   checks = 0;
    int   passed = 0;

    elevator_shaft #(.TRAVEL_TICKS(TRAVEL_TICKS)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .tick         (tick),
        .engine       (engine),
        .doors        (doors),
        .floor_sensor (floor_sensor),
        .car_pos      (car_pos),
        .moving       (moving),
        .arrived      (arrived),
        .fault        (fault),
        .fault_code   (fault_code)
    );

    always #5 CLK = ~CLK;

    function automatic void add_vec(input string name, input logic t, input logic [1:0] eng,
                                    input logic [2:0] d, input int pos, input logic [2:0] sen,
                                    input logic mov, input logic arr, input logic flt,
                                    input logic [2:0] code);
        vec_t v;
        v.name        = name;
        v.tick        = t;
        v.engine      = eng;
        v.doors       = d;
        v.exp.pos     = POSW'(pos);
        v.exp.sensor  = sen;
        v.exp.moving  = mov;
        v.exp.arrived = arr;
        v.exp.fault   = flt;
        v.exp.code    = code;
        vecs.push_back(v);
    endfunction

    task automatic check_output(input string name);
        out_t act;
        out_t exp;
        act = {car_pos, floor_sensor, moving, arrived, fault, fault_code};
        checks++;
        if (exp_q.size() == 0) begin
            $display("[TB] FAIL %s: scoreboard empty, got pos=%0d", name, car_pos);
            return;
        end
        exp = exp_q.pop_front();
        if (act === exp)
            passed++;
        else
            $display("[TB] FAIL %s: got pos=%0d sensor=%b moving=%b arrived=%b fault=%b code=%0d, expected pos=%0d sensor=%b moving=%b arrived=%b fault=%b code=%0d",
                     name, act.pos, act.sensor, act.moving, act.arrived, act.fault, act.code,
                     exp.pos, exp.sensor, exp.moving, exp.arrived, exp.fault, exp.code);
    endtask

    task automatic apply_stimulus(input vec_t v);
        @(negedge CLK);
        tick   = v.tick;
        engine = v.engine;
        doors  = v.doors;
        exp_q.push_back(v.exp);
        @(posedge CLK);
        #1;
        check_output(v.name);
    endtask

    task automatic run_table();
        foreach (vecs[i])
            apply_stimulus(vecs[i]);
        vecs.delete();
    endtask

    // Reset is asserted away from any clock edge and checked before the next edge arrives.
    task automatic do_reset(input string name);
        out_t r;
        r = {POSW'(0), 3'b001, 1'b0, 1'b0, 1'b0, FC_NONE};
        @(negedge CLK);
        RST    = 1'b0;
        tick   = 1'b0;
        engine = ENG_OFF;
        doors  = 3'b000;
        exp_q.push_back(r);
        #1;
        check_output(name);
        @(posedge CLK);
        #2;
        RST = 1'b1;
    endtask

    function automatic void add_climb_to_f2();
        add_vec("up_t1", 1, ENG_UP, 3'b000, 1, 3'b000, 1, 0, 0, FC_NONE);
        add_vec("up_t2", 1, ENG_UP, 3'b000, 2, 3'b000, 1, 0, 0, FC_NONE);
        add_vec("up_t3", 1, ENG_UP, 3'b000, 3, 3'b000, 1, 0, 0, FC_NONE);
        add_vec("up_t4", 1, ENG_UP, 3'b000, 4, 3'b010, 1, 1, 0, FC_NONE);
    endfunction

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        do_reset("reset_initial");

        add_vec("first_tick_ignored", 1, ENG_UP, 3'b000, 0, 3'b001, 0, 0, 0, FC_NONE);
        add_vec("up_t1",      1, ENG_UP,   3'b000, 1, 3'b000, 1, 0, 0, FC_NONE);
        add_vec("up_no_tick", 0, ENG_UP,   3'b000, 1, 3'b000, 1, 0, 0, FC_NONE);
        add_vec("up_t2",      1, ENG_UP,   3'b000, 2, 3'b000, 1, 0, 0, FC_NONE);
        add_vec("up_t3",      1, ENG_UP,   3'b000, 3, 3'b000, 1, 0, 0, FC_NONE);
        add_vec("up_t4_f2",   1, ENG_UP,   3'b000, 4, 3'b010, 1, 1, 0, FC_NONE);
        add_vec("hold_f2",    0, ENG_UP,   3'b000, 4, 3'b010, 1, 0, 0, FC_NONE);
        add_vec("up_t5",      1, ENG_UP,   3'b000, 5, 3'b000, 1, 0, 0, FC_NONE);
        add_vec("up_t6",      1, ENG_UP,   3'b000, 6, 3'b000, 1, 0, 0, FC_NONE);
        add_vec("up_t7",      1, ENG_UP,   3'b000, 7, 3'b000, 1, 0, 0, FC_NONE);
        add_vec("up_t8_f3",   1, ENG_UP,   3'b000, 8, 3'b100, 1, 1, 0, FC_NONE);
        add_vec("stop_f3",    1, ENG_OFF,  3'b000, 8, 3'b100, 0, 0, 0, FC_NONE);
        add_vec("overtravel", 1, ENG_UP,   3'b000, 8, 3'b100, 0, 0, 1, FC_OVERTRAVEL);
        add_vec("frozen_tick", 1, ENG_DOWN, 3'b000, 8, 3'b100, 0, 0, 1, FC_OVERTRAVEL);
        add_vec("frozen_bad",  0, ENG_BAD,  3'b111, 8, 3'b100, 0, 0, 1, FC_OVERTRAVEL);
        run_table();
        do_reset("reset_from_fault");

        add_vec("settle", 0, ENG_OFF, 3'b000, 0, 3'b001, 0, 0, 0, FC_NONE);
        add_vec("up_t1",  1, ENG_UP,  3'b000, 1, 3'b000, 1, 0, 0, FC_NONE);
        add_vec("up_t2",  1, ENG_UP,  3'b000, 2, 3'b000, 1, 0, 0, FC_NONE);
        add_vec("up_t3",  1, ENG_UP,  3'b000, 3, 3'b000, 1, 0, 0, FC_NONE);
        run_table();
        do_reset("reset_mid_travel");

        add_vec("door_open_idle_ok", 0, ENG_OFF, 3'b001, 0, 3'b001, 0, 0, 0, FC_NONE);
        add_vec("door_interlock",    0, ENG_UP,  3'b001, 0, 3'b001, 0, 0, 1, FC_DOOR_MOVE);
        run_table();
        do_reset("reset_after_door");

        add_vec("multi_door", 0, ENG_UP, 3'b011, 0, 3'b001, 0, 0, 1, FC_MULTI_DOOR);
        run_table();
        do_reset("reset_after_multi");

        add_vec("settle",   0, ENG_OFF,  3'b000, 0, 3'b001, 0, 0, 0, FC_NONE);
        add_vec("up_t1",    1, ENG_UP,   3'b000, 1, 3'b000, 1, 0, 0, FC_NONE);
        add_vec("up_t2",    1, ENG_UP,   3'b000, 2, 3'b000, 1, 0, 0, FC_NONE);
        add_vec("reversal", 1, ENG_DOWN, 3'b000, 2, 3'b000, 0, 0, 1, FC_REVERSAL);
        run_table();
        do_reset("reset_after_reversal");

        add_vec("settle",         0, ENG_OFF, 3'b000, 0, 3'b001, 0, 0, 0, FC_NONE);
        add_vec("up_t1",          1, ENG_UP,  3'b000, 1, 3'b000, 1, 0, 0, FC_NONE);
        add_vec("bad_engine_pri", 0, ENG_BAD, 3'b011, 1, 3'b000, 0, 0, 1, FC_ENGINE);
        run_table();
        do_reset("reset_after_bad_engine");

        add_vec("settle", 0, ENG_OFF, 3'b000, 0, 3'b001, 0, 0, 0, FC_NONE);
        add_climb_to_f2();
        add_vec("stop_f2",  1, ENG_OFF, 3'b000, 4, 3'b010, 0, 0, 0, FC_NONE);
        add_vec("misalign", 0, ENG_OFF, 3'b100, 4, 3'b010, 0, 0, 1, FC_MISALIGN);
        run_table();
        do_reset("reset_after_misalign");

        add_vec("settle", 0, ENG_OFF, 3'b000, 0, 3'b001, 0, 0, 0, FC_NONE);
        add_climb_to_f2();
        add_vec("stop_f2",     1, ENG_OFF,  3'b000, 4, 3'b010, 0, 0, 0, FC_NONE);
        add_vec("dn_t1",       1, ENG_DOWN, 3'b000, 3, 3'b000, 1, 0, 0, FC_NONE);
        add_vec("dn_t2",       1, ENG_DOWN, 3'b000, 2, 3'b000, 1, 0, 0, FC_NONE);
        add_vec("dn_t3",       1, ENG_DOWN, 3'b000, 1, 3'b000, 1, 0, 0, FC_NONE);
        add_vec("dn_t4_f1",    1, ENG_DOWN, 3'b000, 0, 3'b001, 1, 1, 0, FC_NONE);
        add_vec("undertravel", 1, ENG_DOWN, 3'b000, 0, 3'b001, 0, 0, 1, FC_OVERTRAVEL);
        run_table();
        do_reset("reset_final");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
